// File: rtl/bp_be_late_wb_buffer_pkg.sv
// Shared types for the backend late-writeback path.
//   bp_be_wb_pkt_s      writeback packet (int/FP/PTW write enables, rd address, data)
//   late_wb_els_gp      depth of the late-writeback buffer assumed by the issue-credit check
//   late_wb_classify()  routes an incoming late packet: PTW bypass, enqueue, or drop
package bp_be_late_wb_buffer_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int unsigned dpath_width_gp    = 64;
  localparam int unsigned reg_addr_width_gp = 5;
  localparam int unsigned late_wb_els_gp    = 4;

  typedef struct packed {
    logic                         ird_w_v;
    logic                         frd_w_v;
    logic                         ptw_w_v;
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic [dpath_width_gp-1:0]    rd_data;
  } bp_be_wb_pkt_s;

  typedef enum logic [1:0] {
    e_late_wb_drop = 2'd0,
    e_late_wb_ptw  = 2'd1,
    e_late_wb_enq  = 2'd2
  } late_wb_cls_e;

  // Packet width implied by a processor configuration.
  function automatic int unsigned wb_pkt_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 3 + reg_addr_width_gp + dpath_width_gp;
      default:          return 3 + reg_addr_width_gp + dpath_width_gp;
    endcase
  endfunction

  // PTW wins over register writes; integer writes to x0 are discarded.
  function automatic late_wb_cls_e late_wb_classify(input logic v, input bp_be_wb_pkt_s pkt);
    if (!v)                                   return e_late_wb_drop;
    if (pkt.ptw_w_v)                          return e_late_wb_ptw;
    if (pkt.ird_w_v && (pkt.rd_addr == '0))   return e_late_wb_drop;
    if (pkt.ird_w_v || pkt.frd_w_v)           return e_late_wb_enq;
    return e_late_wb_drop;
  endfunction

endpackage

// File: rtl/bp_be_late_wb_buffer_if.sv
// Bundle of the late-writeback buffer data/handshake signals.
//   late_wb_pkt_i/late_wb_v_i  packet from the memory pipe (no backpressure)
//   iwb_*                      head packet toward the int regfile late port (valid/yumi)
//   fwb_*                      head packet toward the FP regfile late port (valid/yumi)
//   ptw_*                      PTW return bypass
//   credits_full_o/empty_o     issue credit status
// slave: the buffer itself; master: its environment.
interface bp_be_late_wb_buffer_if;
  import bp_be_late_wb_buffer_pkg::*;

  bp_be_wb_pkt_s late_wb_pkt_i;
  logic          late_wb_v_i;
  bp_be_wb_pkt_s iwb_pkt_o;
  logic          iwb_v_o;
  logic          iwb_yumi_i;
  bp_be_wb_pkt_s fwb_pkt_o;
  logic          fwb_v_o;
  logic          fwb_yumi_i;
  bp_be_wb_pkt_s ptw_pkt_o;
  logic          ptw_v_o;
  logic          credits_full_o;
  logic          credits_empty_o;

  modport slave (
    input  late_wb_pkt_i, late_wb_v_i, iwb_yumi_i, fwb_yumi_i,
    output iwb_pkt_o, iwb_v_o, fwb_pkt_o, fwb_v_o, ptw_pkt_o, ptw_v_o,
           credits_full_o, credits_empty_o
  );

  modport master (
    output late_wb_pkt_i, late_wb_v_i, iwb_yumi_i, fwb_yumi_i,
    input  iwb_pkt_o, iwb_v_o, fwb_pkt_o, fwb_v_o, ptw_pkt_o, ptw_v_o,
           credits_full_o, credits_empty_o
  );

endinterface

// File: rtl/bp_be_late_wb_fifo_ctrl.sv
// Pointer/occupancy control for the late-writeback queue.
//   clk_i, reset_n_i  clock, async active-low reset
//   enq_req_i         incoming packet classified for enqueue
//   deq_i             head consumed this cycle
//   enq_o             enqueue actually performed (write enable for storage)
//   wptr_o, rptr_o    write/read slot, wrap modulo els_p
//   count_o           occupancy 0..els_p
//   credits_full_o    registered count >= els_p-1
//   credits_empty_o   registered count == 0
module bp_be_late_wb_fifo_ctrl #(
  parameter int unsigned els_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enq_req_i,
  input  logic                       deq_i,
  output logic                       enq_o,
  output logic [$clog2(els_p)-1:0]   wptr_o,
  output logic [$clog2(els_p)-1:0]   rptr_o,
  output logic [$clog2(els_p+1)-1:0] count_o,
  output logic                       credits_full_o,
  output logic                       credits_empty_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p+1);

  if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
    $error("bp_be_late_wb_fifo_ctrl: els_p must be a power of two >= 2");
  end

  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                credits_full_q, credits_empty_q;
  logic                full;

  assign full  = (count_q == cnt_w_lp'(els_p));
  // A dequeue in the same cycle frees the slot, so a full queue may still accept.
  assign enq_o = enq_req_i && (!full || deq_i);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (enq_o) wptr_d = wptr_q + 1'b1;
    if (deq_i) rptr_d = rptr_q + 1'b1;
    if (enq_o && !deq_i)      count_d = count_q + 1'b1;
    else if (!enq_o && deq_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      credits_full_q  <= 1'b0;
      credits_empty_q <= 1'b1;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      // Credits track the previous cycle's occupancy.
      credits_full_q  <= (count_q >= cnt_w_lp'(els_p - 1));
      credits_empty_q <= (count_q == '0);
    end
  end

  assign wptr_o          = wptr_q;
  assign rptr_o          = rptr_q;
  assign count_o         = count_q;
  assign credits_full_o  = credits_full_q;
  assign credits_empty_o = credits_empty_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(enq_req_i && full && !deq_i))
    else $error("late wb buffer overflow: packet dropped");

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(deq_i && (count_q == '0)))
    else $error("late wb buffer dequeue while empty");

endmodule

// File: rtl/bp_be_late_wb_buffer.sv
// Late writeback buffer between the memory pipe and the regfile late write ports.
//   clk_i      clock
//   reset_n_i  async active-low reset
//   wb_if      slave side of bp_be_late_wb_buffer_if:
//                late_wb_pkt_i/v_i in; iwb/fwb head toward int/FP late ports with yumi;
//                ptw_* combinational PTW bypass; credits_full/empty_o for issue.
// Non-PTW register writes are queued strictly in order; the head is offered to the int
// port if it writes an int register, otherwise to the FP port.
module bp_be_late_wb_buffer
  import bp_be_late_wb_buffer_pkg::*;
#(
  parameter bp_params_e  bp_params_p = e_bp_default_cfg,
  parameter int unsigned els_p       = 4
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  bp_be_late_wb_buffer_if.slave  wb_if
);

  localparam int unsigned wb_pkt_width_lp = wb_pkt_width(bp_params_p);
  localparam int unsigned ptr_w_lp        = $clog2(els_p);
  localparam int unsigned cnt_w_lp        = $clog2(els_p+1);

  if (wb_pkt_width_lp != $bits(bp_be_wb_pkt_s)) begin : g_bad_width
    $error("bp_be_late_wb_buffer: packet width does not match configuration");
  end

  late_wb_cls_e        cls;
  logic                enq_req, enq, deq;
  logic                nonempty, iwb_v, fwb_v;
  logic [ptr_w_lp-1:0] wptr, rptr;
  logic [cnt_w_lp-1:0] count;
  bp_be_wb_pkt_s       mem_q [els_p];
  bp_be_wb_pkt_s       head;

  assign cls     = late_wb_classify(wb_if.late_wb_v_i, wb_if.late_wb_pkt_i);
  assign enq_req = (cls == e_late_wb_enq);

  bp_be_late_wb_fifo_ctrl #(
    .els_p(els_p)
  ) fifo_ctrl (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .enq_req_i      (enq_req),
    .deq_i          (deq),
    .enq_o          (enq),
    .wptr_o         (wptr),
    .rptr_o         (rptr),
    .count_o        (count),
    .credits_full_o (wb_if.credits_full_o),
    .credits_empty_o(wb_if.credits_empty_o)
  );

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr] <= wb_if.late_wb_pkt_i;
  end

  assign head     = mem_q[rptr];
  assign nonempty = (count != '0);
  // Enqueued entries always write int or FP, so !ird implies frd.
  assign iwb_v    = nonempty &&  head.ird_w_v;
  assign fwb_v    = nonempty && !head.ird_w_v;
  assign deq      = (iwb_v && wb_if.iwb_yumi_i) || (fwb_v && wb_if.fwb_yumi_i);

  assign wb_if.iwb_pkt_o = head;
  assign wb_if.fwb_pkt_o = head;
  assign wb_if.iwb_v_o   = iwb_v;
  assign wb_if.fwb_v_o   = fwb_v;
  assign wb_if.ptw_pkt_o = wb_if.late_wb_pkt_i;
  assign wb_if.ptw_v_o   = (cls == e_late_wb_ptw);

  a_iwb_yumi_proto: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(wb_if.iwb_yumi_i && !iwb_v))
    else $error("iwb_yumi_i without iwb_v_o");

  a_fwb_yumi_proto: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(wb_if.fwb_yumi_i && !fwb_v))
    else $error("fwb_yumi_i without fwb_v_o");

endmodule

// File: tb/tb_bp_be_late_wb_buffer.sv
// Scoreboard bench for bp_be_late_wb_buffer: a queue model predicts per-cycle outputs and
// drain order; a monitor process compares the DUT against those predictions.
module tb_bp_be_late_wb_buffer;
  import bp_be_late_wb_buffer_pkg::*;

  localparam int unsigned ELS = late_wb_els_gp;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_be_late_wb_buffer_if wb_if();

  bp_be_late_wb_buffer #(
    .bp_params_p(e_bp_default_cfg),
    .els_p      (ELS)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .wb_if    (wb_if)
  );

  typedef struct {
    logic          iv, fv, cf, ce, pv;
    bp_be_wb_pkt_s pp;
  } cyc_exp_t;

  typedef struct {
    logic          is_int;
    bp_be_wb_pkt_s pkt;
  } drain_t;

  cyc_exp_t      cyc_q[$];
  drain_t        sb_q[$];
  bp_be_wb_pkt_s model_q[$];
  int unsigned   prev_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  function automatic void chk(input string n, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, req, $time);
    end
  endfunction

  function automatic bp_be_wb_pkt_s mk(input logic ird, input logic frd, input logic ptw,
                                       input int unsigned rd, input logic [63:0] data);
    bp_be_wb_pkt_s p;
    p.ird_w_v = ird;
    p.frd_w_v = frd;
    p.ptw_w_v = ptw;
    p.rd_addr = 5'(rd);
    p.rd_data = data;
    return p;
  endfunction

  function automatic bp_be_wb_pkt_s rand_pkt();
    bp_be_wb_pkt_s p;
    int unsigned   k;
    k = $urandom_range(0, 9);
    p = mk(1'b0, 1'b0, 1'b0, $urandom_range(1, 31), {$urandom(), $urandom()});
    case (k)
      0:          begin p.ptw_w_v = 1'b1; p.ird_w_v = 1'($urandom_range(0, 1)); end
      1, 2, 3, 4: p.ird_w_v = 1'b1;
      5, 6, 7:    begin p.frd_w_v = 1'b1; p.rd_addr = 5'($urandom_range(0, 31)); end
      8:          begin p.ird_w_v = 1'b1; p.rd_addr = '0; end
      default:    ;
    endcase
    return p;
  endfunction

  // One clock of stimulus; the model is advanced to the state after the next posedge.
  task automatic do_cycle(input logic rst_n, input logic v, input bp_be_wb_pkt_s p,
                          input logic want_i, input logic want_f);
    cyc_exp_t    e;
    drain_t      d;
    int unsigned cur;
    logic        keep, yi, yf;
    @(negedge clk);
    reset_n = rst_n;
    cur = model_q.size();
    if (!rst_n) begin
      model_q.delete();
      prev_cnt = 0;
      e.iv = 1'b0; e.fv = 1'b0; e.cf = 1'b0; e.ce = 1'b1;
      yi = 1'b0; yf = 1'b0;
    end else begin
      e.iv = (cur > 0) &&  model_q[0].ird_w_v;
      e.fv = (cur > 0) && !model_q[0].ird_w_v;
      e.cf = (prev_cnt >= ELS - 1);
      e.ce = (prev_cnt == 0);
      yi = want_i && e.iv;
      yf = want_f && e.fv;
      keep = v && !p.ptw_w_v && (p.ird_w_v ? (p.rd_addr != 0) : p.frd_w_v);
      // Overflow is an assertion, so the stimulus never creates one.
      if (keep && (cur - ((yi || yf) ? 1 : 0)) >= ELS) begin
        v = 1'b0;
        keep = 1'b0;
      end
      if (yi || yf) begin
        d.is_int = yi;
        d.pkt    = model_q.pop_front();
        sb_q.push_back(d);
      end
      if (keep) model_q.push_back(p);
      prev_cnt = cur;
    end
    e.pv = v && p.ptw_w_v;
    e.pp = p;
    wb_if.late_wb_v_i   = v;
    wb_if.late_wb_pkt_i = p;
    wb_if.iwb_yumi_i    = yi;
    wb_if.fwb_yumi_i    = yf;
    cyc_q.push_back(e);
  endtask

  task automatic idle(input int unsigned n, input logic want_i, input logic want_f);
    for (int unsigned i = 0; i < n; i++) do_cycle(1'b1, 1'b0, '0, want_i, want_f);
  endtask

  // Monitor: compares DUT outputs against the expectations queued by the driver.
  initial begin
    cyc_exp_t c;
    drain_t   d;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        chk("iwb_v", 128'(wb_if.iwb_v_o), 128'(c.iv));
        chk("fwb_v", 128'(wb_if.fwb_v_o), 128'(c.fv));
        chk("credits_full", 128'(wb_if.credits_full_o), 128'(c.cf));
        chk("credits_empty", 128'(wb_if.credits_empty_o), 128'(c.ce));
        chk("ptw_v", 128'(wb_if.ptw_v_o), 128'(c.pv));
        if (c.pv) chk("ptw_pkt", 128'(wb_if.ptw_pkt_o), 128'(c.pp));
        if (wb_if.iwb_yumi_i || wb_if.fwb_yumi_i) begin
          if (sb_q.size() == 0) begin
            chk("drain_unexpected", 128'(1), 128'(0));
          end else begin
            d = sb_q.pop_front();
            if (d.is_int) begin
              chk("drain_int_hs", 128'(wb_if.iwb_v_o && wb_if.iwb_yumi_i), 128'(1));
              chk("drain_int_pkt", 128'(wb_if.iwb_pkt_o), 128'(d.pkt));
            end else begin
              chk("drain_fp_hs", 128'(wb_if.fwb_v_o && wb_if.fwb_yumi_i), 128'(1));
              chk("drain_fp_pkt", 128'(wb_if.fwb_pkt_o), 128'(d.pkt));
            end
          end
        end
      end
    end
  end

  initial begin
    logic wi, wf;
    wb_if.late_wb_v_i   = 1'b0;
    wb_if.late_wb_pkt_i = '0;
    wb_if.iwb_yumi_i    = 1'b0;
    wb_if.fwb_yumi_i    = 1'b0;

    // Reset, with a PTW packet showing the bypass is live during reset.
    do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, mk(1'b0, 1'b0, 1'b1, 2, 64'h1234), 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Single int write, consumed as soon as it is visible.
    do_cycle(1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 5, 64'hDEAD), 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);

    // In-order drain: FP behind an un-granted int head must wait.
    do_cycle(1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 3, 64'h3333), 1'b0, 1'b1);
    do_cycle(1'b1, 1'b1, mk(1'b0, 1'b1, 1'b0, 7, 64'h7777), 1'b0, 1'b1);
    do_cycle(1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 9, 64'h9999), 1'b0, 1'b1);
    idle(1, 1'b0, 1'b1);
    idle(5, 1'b1, 1'b1);

    // Fill to capacity, let credits settle, then enq+deq while full.
    for (int unsigned i = 0; i < ELS; i++)
      do_cycle(1'b1, 1'b1, mk(i[0], !i[0], 1'b0, 10 + i, 64'(32'hF000 + i)), 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 20, 64'hABCD), 1'b1, 1'b1);
    // PTW and droppable packets while full leave occupancy alone.
    do_cycle(1'b1, 1'b1, mk(1'b0, 1'b0, 1'b1, 4, 64'hBEEF), 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 0, 64'h0BAD), 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, mk(1'b0, 1'b0, 1'b0, 6, 64'h0BAD), 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(8, 1'b1, 1'b1);

    // Reset with three entries queued; afterwards the queue is empty.
    for (int unsigned i = 0; i < 3; i++)
      do_cycle(1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 1 + i, 64'(i)), 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b1);

    // Randomized traffic with alternating drain regimes.
    for (int unsigned i = 0; i < 3000; i++) begin
      case ((i / 50) % 3)
        0:       begin wi = 1'($urandom_range(0, 1)); wf = 1'($urandom_range(0, 1)); end
        1:       begin wi = 1'b0; wf = 1'b0; end
        default: begin wi = 1'b1; wf = 1'b1; end
      endcase
      if (i == 1500) do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
      else do_cycle(1'b1, 1'($urandom_range(0, 3) != 0), rand_pkt(), wi, wf);
    end
    idle(10, 1'b1, 1'b1);

    repeat (2) @(negedge clk);
    #3;
    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    chk("model_drained", 128'(wb_if.credits_empty_o), 128'(model_q.size() == 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
